// File: rtl/id_emit.sv
// id_emit: emits an ASCII identifier token: letters, then the decimal form of a value, over valid/ready.
// Define ID_TERM_EN to append a single space terminator after the last digit.
module id_emit #(
  parameter int MAX_LET = 8,
  parameter int VAL_W = 16,
  parameter int NDIG = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       let_base,
  input  logic [3:0]       let_cnt,
  input  logic [VAL_W-1:0] value,
  output logic [7:0]       char,
  output logic             char_valid,
  input  logic             char_ready,
  output logic             busy,
  output logic             done
);
  localparam int AW = 4*NDIG + VAL_W;
  localparam int DW = $clog2(NDIG + 1);
  localparam int SW = $clog2(VAL_W + 1);
  localparam logic [3:0] MAXL = 4'(MAX_LET);
  typedef enum logic [2:0] {
    IDLE, CONV, LET, DIG
`ifdef ID_TERM_EN
    , TERM
`endif
  } state_t;
  state_t state, nxt;
  logic [AW-1:0] acc;
  logic [4*NDIG-1:0] adj;
  logic [SW-1:0] step;
  logic [DW-1:0] dig_idx, first;
  logic [7:0] cur;
  logic [3:0] left, digit;
  logic xfer, is_alpha, done_n;
  assign xfer = char_valid && char_ready;
  assign busy = state != IDLE;
  assign digit = acc[VAL_W + 4*dig_idx +: 4];
  assign is_alpha = (let_base >= "a" && let_base <= "z") || (let_base >= "A" && let_base <= "Z");
  // BCD digits occupy the top of acc; the binary value shifts out of the bottom
  always_comb begin
    adj = '0;
    first = '0;
    for (int i = 0; i < NDIG; i++) begin
      adj[4*i +: 4] = acc[VAL_W + 4*i +: 4] >= 4'd5 ? acc[VAL_W + 4*i +: 4] + 4'd3 : acc[VAL_W + 4*i +: 4];
      if (acc[VAL_W + 4*i +: 4] != 4'd0) first = DW'(i);
    end
  end
  always_comb begin
    char = 8'h00;
    char_valid = 1'b0;
    if (state == LET) begin
      char = cur;
      char_valid = 1'b1;
    end
    if (state == DIG) begin
      char = 8'h30 + {4'h0, digit};
      char_valid = 1'b1;
    end
`ifdef ID_TERM_EN
    if (state == TERM) begin
      char = 8'h20;
      char_valid = 1'b1;
    end
`endif
  end
  always_comb begin
    nxt = state;
    done_n = 1'b0;
    case (state)
      IDLE: nxt = start ? CONV : IDLE;
      CONV: nxt = step == SW'(VAL_W) ? LET : CONV;
      LET:  nxt = xfer && left == 4'd1 ? DIG : LET;
      DIG: begin
        if (xfer && dig_idx == '0) begin
`ifdef ID_TERM_EN
          nxt = TERM;
`else
          nxt = IDLE;
          done_n = 1'b1;
`endif
        end
      end
`ifdef ID_TERM_EN
      TERM: begin
        nxt = xfer ? IDLE : TERM;
        done_n = xfer;
      end
`endif
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      done <= 1'b0;
    end else begin
      state <= nxt;
      done <= done_n;
    end
  end
  // the cycle after the last shift picks the first nonzero digit for leading-zero suppression
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      step <= '0;
      dig_idx <= '0;
      cur <= '0;
      left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= AW'(value);
            step <= '0;
            cur <= is_alpha ? let_base : "a";
            left <= let_cnt == 4'd0 ? 4'd1 : let_cnt > MAXL ? MAXL : let_cnt;
          end
        end
        CONV: begin
          if (step != SW'(VAL_W)) begin
            acc <= {adj, acc[VAL_W-1:0]} << 1;
            step <= step + 1'b1;
          end else dig_idx <= first;
        end
        LET: begin
          if (xfer) begin
            cur <= cur == "z" ? "a" : cur == "Z" ? "A" : cur + 8'd1;
            left <= left - 4'd1;
          end
        end
        DIG: if (xfer && dig_idx != '0) dig_idx <= dig_idx - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_id_emit.sv
// tb_id_emit: scoreboard bench for id_emit; expected characters are queued at stimulus and checked by a monitor.
module tb_id_emit;
  logic clk = 0, reset = 1, start = 0, char_ready = 1;
  logic char_valid, busy, done;
  logic [7:0] let_base = 8'h00, char;
  logic [3:0] let_cnt = 4'd0;
  logic [15:0] value = 16'd0;
  int n_cmp = 0, n_bad = 0, rk = 0;
  logic [7:0] q[$];
  logic [5:0] pat = 6'b101001;
  bit stall_mode = 0, stalled = 0;
  logic [7:0] held = 8'h00;

  id_emit dut (
    .clk(clk), .reset(reset), .start(start), .let_base(let_base), .let_cnt(let_cnt),
    .value(value), .char(char), .char_valid(char_valid), .char_ready(char_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    char_ready = stall_mode ? pat[rk % 6] : 1'b1;
    rk++;
  end

  initial forever begin
    @(negedge clk);
    if (reset) stalled = 0;
    else begin
      if (stalled) begin
        chk("stall_valid", 32'(char_valid), 32'd1);
        if (char_valid) chk("stall_hold", 32'(char), 32'(held));
      end
      if (char_valid && char_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_char: got %0h expected none", char);
        end else chk("char", 32'(char), 32'(q.pop_front()));
      end
      stalled = char_valid && !char_ready;
      held = char;
    end
  end

  task automatic run(input string tag, input logic [7:0] b, input logic [3:0] n, input logic [15:0] v,
                     input string exp_in, input bit stall, input bit stray);
    int k, first_k, len;
    bit got;
    string exp;
    exp = exp_in;
`ifdef ID_TERM_EN
    exp = {exp, " "};
`endif
    for (int i = 0; i < exp.len(); i++) q.push_back(exp[i]);
    len = exp.len();
    stall_mode = stall;
    rk = 0;
    @(posedge clk);
    #1;
    let_base = b; let_cnt = n; value = v; start = 1;
    @(posedge clk);
    #1;
    start = 0; let_base = 8'h00; let_cnt = 4'd0; value = 16'hffff;
    k = 0; first_k = -1; got = 0;
    while (k < 400 && !got) begin
      @(negedge clk);
      if (char_valid && first_k < 0) first_k = k;
      if (done) got = 1;
      else begin
        @(posedge clk);
        k++;
        #1;
        start = stray && k >= 2 && k <= 20 && (k % 3 == 0);
      end
    end
    start = 0;
    chk($sformatf("%s_done_seen", tag), 32'(got), 32'd1);
    if (got) begin
      chk($sformatf("%s_busy_at_done", tag), 32'(busy), 32'd0);
      chk($sformatf("%s_all_sent", tag), 32'(q.size()), 32'd0);
      if (!stall) begin
        chk($sformatf("%s_first_valid", tag), 32'(first_k), 32'd17);
        chk($sformatf("%s_done_cycle", tag), 32'(k), 32'(first_k + len));
      end
      @(posedge clk);
      #1;
      chk($sformatf("%s_done_one_cycle", tag), 32'(done), 32'd0);
    end
    q.delete();
    stall_mode = 0;
  endtask

  task automatic reset_mid();
    string exp;
    exp = "mnopqrst5";
    for (int i = 0; i < exp.len(); i++) q.push_back(exp[i]);
    @(posedge clk);
    #1;
    let_base = "m"; let_cnt = 4'd8; value = 16'd5; start = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (19) @(posedge clk);
    #1;
    chk("busy_before_rst", 32'(busy), 32'd1);
    chk("valid_before_rst", 32'(char_valid), 32'd1);
    #1;
    reset = 1;
    #1;
    chk("rst_valid", 32'(char_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_char", 32'(char), 32'd0);
    q.delete();
    @(posedge clk);
    #3;
    reset = 0;
    repeat (3) @(posedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #12;
    chk("reset_char", 32'(char), 32'd0);
    chk("reset_valid", 32'(char_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    reset = 0;
    run("abc42", "a", 4'd3, 16'd42, "abc42", 0, 0);
    run("x0", "X", 4'd1, 16'd0, "X0", 0, 0);
    run("wrap", "y", 4'd4, 16'd65535, "yzab65535", 0, 0);
    run("stall", "a", 4'd2, 16'd907, "ab907", 1, 0);
    run("cnt0", "5", 4'd0, 16'd7, "a7", 0, 0);
    run("cnt15", "a", 4'd15, 16'd100, "abcdefgh100", 0, 0);
    run("stray", "Q", 4'd2, 16'd12345, "QR12345", 0, 1);
    reset_mid();
    run("after_rst", "c", 4'd1, 16'd9, "c9", 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
